hex_segment_reader: RTL and testbench
=====================================

# hex_segment_reader

Monitor-side reader for the board's active-low 7-segment display buses. It samples the HEX0..HEX(N-1) segment outputs of the design under monitor and waits until they have held stable. Each new stable display content is decoded back into hex nibbles and streamed one digit per beat over a valid/ready handshake to the monitor link. It is the inverse of the per-digit hex-to-segment encoder used on the display outputs.

## Interface
Parameters:
- NUM_DIGITS, 6: number of 7-segment digits monitored; legal range 1..8.
- STABLE_CYCLES, 4: consecutive unchanged cycles required before a display state is accepted; legal range 1..255.

Ports:
- clk  input  1  system clock; the only clock.
- reset_n  input  1  reset, asynchronous assert, active-low.
- hex_in  input  7*NUM_DIGITS  segment buses, active-low. Digit i occupies [7i+6:7i]; bit 0 = segment a … bit 6 = segment g.
- out_valid  output  1  digit beat available.
- out_ready  input  1  consumer accepts beat.
- out_digit  output  4  decoded nibble of current beat.
- out_index  output  3  digit number of current beat (0 = HEX0).
- out_known  output  1  pattern matched one of the 16 hex glyphs.
- out_blank  output  1  all segments off.
- out_last  output  1  beat is digit NUM_DIGITS-1.

## Operation
- Sample register s captures hex_in every cycle.
- Stability counter cnt, saturating at STABLE_CYCLES. If hex_in != s at an edge, cnt <= 0; otherwise, if cnt < STABLE_CYCLES, cnt increments. The display is stable when cnt == STABLE_CYCLES.
- Committed register c holds the last frame sent. It resets to all ones (every digit blank).
- FSM states:
  - IDLE: when stable and s != c, set c <= s, idx <= 0, and go to SEND. Otherwise remain in IDLE.
  - SEND: out_valid = 1. On out_valid && out_ready: if idx == NUM_DIGITS-1, go to IDLE; otherwise idx increments.
- Beat payload is decoded from c[idx], never from s, so the payload is frozen while a beat waits.
- Decode: invert to active-high p, then match p against the glyph set:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=27, 8=7F, 9=6F, A=77, b=7C, C=58, d=5E, E=79, F=71.
  - Match: out_known=1, out_digit = the matching value.
  - p == 00: out_blank=1, out_known=0, out_digit=0.
  - Any other pattern: out_known=0, out_blank=0, out_digit=0.
- out_last = (idx == NUM_DIGITS-1). out_index = idx, zero-extended.
- Display changes during SEND do not disturb the frame in flight. Sampling and the stability count keep running. On return to IDLE the latest stable value is compared with c. Intermediate states are dropped; the final state is always sent.
- A stable value equal to c produces no frame, so an unchanged display is never re-sent.

## Timing
- Reset values: out_valid=0, out_digit=0, out_index=0, out_known=0, out_blank=1, out_last=(NUM_DIGITS==1), state=IDLE, cnt=0, s=all ones, c=all ones.
- Latency: let edge k be the first edge at which new hex_in is captured into s. cnt reaches STABLE_CYCLES at edge k+STABLE_CYCLES. The commit happens at edge k+STABLE_CYCLES+1, and out_valid is high after that edge.
- Handshake rules:
  - out_valid, once high, stays high until accepted.
  - The payload is constant while out_valid && !out_ready.
  - With out_ready held high, one beat transfers per cycle, so a frame takes NUM_DIGITS cycles.
  - After the last beat, at least one IDLE cycle precedes the next frame.
- All outputs are registered or decoded from registered state only; there is no combinational path from hex_in or out_ready.
- reset_n asserted mid-frame: the frame is aborted immediately and all state returns to reset values. After release, the current display is re-evaluated, and a blank display produces no frame.

## Test plan
- Reset release with hex_in all 0x7F (blank) for 20 cycles -> out_valid stays 0.
- HEX0=0x40, HEX1=0x79, others 0x7F, out_ready=1 -> out_valid rises 5 cycles after the capture edge (STABLE_CYCLES=4). Six beats follow:
  - idx0: digit 0, known=1.
  - idx1: digit 1, known=1.
  - idx2..5: blank=1.
  - out_last=1 on idx5 only.
- HEX0 toggles between 0x08 and 0x40 every 3 cycles, then holds 0x08 -> no frame during toggling. Exactly one frame follows after the hold, with idx0 digit A.
- out_ready=0 for 10 cycles during idx2 -> out_valid, out_digit and out_index stay constant; the remaining beats resume when out_ready rises.
- HEX0 changes to 0x79 mid-frame -> the current frame completes with the old value. A second frame then follows with idx0 digit 1 and known=1.
- HEX3=0x7E (segment a only lit) -> idx3 has known=0, blank=0, digit 0. Assert reset_n low during idx1 -> out_valid=0 within the same cycle.

Source files
------------

// File: rtl/hex_segment_reader.sv
// Reads active-low 7-segment buses, waits for a stable display and
// streams each new frame back as decoded hex digits, one per beat.
module hex_segment_reader #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7*NUM_DIGITS-1:0] hex_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_digit,
  output logic [2:0]              out_index,
  output logic                    out_known,
  output logic                    out_blank,
  output logic                    out_last
);

  localparam int         W    = 7 * NUM_DIGITS;
  localparam logic [7:0] SC   = 8'(STABLE_CYCLES);
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [W-1:0] r_s;
  logic [W-1:0] r_c;
  logic [7:0] r_cnt;
  logic [2:0] r_idx;
  logic       w_stable;
  logic       w_commit;
  logic       w_fire;
  logic [6:0] w_dig [8];
  logic [6:0] w_p;

  assign w_stable = (r_cnt == SC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s   <= '1;
      r_cnt <= '0;
    end else begin
      r_s <= hex_in;
      if (hex_in != r_s)
        r_cnt <= '0;
      else if (r_cnt < SC)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    w_fire   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_stable && (r_s != r_c)) begin
          w_commit = 1'b1;
          w_next   = SEND;
        end
      end
      SEND: begin
        w_fire = out_ready;
        if (out_ready && (r_idx == LAST))
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_c     <= '1;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (w_commit) begin
        r_c   <= r_s;
        r_idx <= '0;
      end else if (w_fire && (r_idx != LAST)) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  // Pad to 8 slots so a 3-bit index never reads past the frame
  for (genvar g = 0; g < 8; g++) begin : g_dig
    if (g < NUM_DIGITS) begin : g_used
      assign w_dig[g] = r_c[7*g +: 7];
    end else begin : g_pad
      assign w_dig[g] = 7'h7F;
    end
  end

  assign w_p = ~w_dig[r_idx];

  always_comb begin
    out_digit = 4'h0;
    out_known = 1'b1;
    out_blank = 1'b0;
    unique case (w_p)
      7'h3F: out_digit = 4'h0;
      7'h06: out_digit = 4'h1;
      7'h5B: out_digit = 4'h2;
      7'h4F: out_digit = 4'h3;
      7'h66: out_digit = 4'h4;
      7'h6D: out_digit = 4'h5;
      7'h7D: out_digit = 4'h6;
      7'h27: out_digit = 4'h7;
      7'h7F: out_digit = 4'h8;
      7'h6F: out_digit = 4'h9;
      7'h77: out_digit = 4'hA;
      7'h7C: out_digit = 4'hB;
      7'h58: out_digit = 4'hC;
      7'h5E: out_digit = 4'hD;
      7'h79: out_digit = 4'hE;
      7'h71: out_digit = 4'hF;
      7'h00: begin
        out_known = 1'b0;
        out_blank = 1'b1;
      end
      default: out_known = 1'b0;
    endcase
  end

  assign out_valid = (r_state == SEND);
  assign out_index = r_idx;
  assign out_last  = (r_idx == LAST);

endmodule

// File: tb/tb_hex_segment_reader.sv
// Bench for hex_segment_reader: scoreboard of expected beats,
// popped and compared on every accepted handshake.
module tb_hex_segment_reader;

  localparam int N  = 6;
  localparam int SC = 4;
  localparam logic [41:0] BLANK = '1;

  localparam logic [6:0] GLY [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h27,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h58, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [3:0] digit;
    logic [2:0] index;
    logic       known;
    logic       blank;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [41:0] hex;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_digit;
  logic [2:0]  out_index;
  logic        out_known;
  logic        out_blank;
  logic        out_last;

  beat_t sb[$];
  int    n_chk = 0;
  int    n_err = 0;

  hex_segment_reader #(
    .NUM_DIGITS   (N),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .hex_in   (hex),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_digit(out_digit),
    .out_index(out_index),
    .out_known(out_known),
    .out_blank(out_blank),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic beat_t model(
    input logic [6:0] h,
    input int         i
  );
    beat_t      b;
    logic [6:0] p;
    p       = ~h;
    b.digit = 4'h0;
    b.known = 1'b0;
    b.blank = (p == 7'h00);
    for (int d = 0; d < 16; d++) begin
      if (GLY[d] == p) begin
        b.known = 1'b1;
        b.digit = 4'(d);
      end
    end
    b.index = 3'(i);
    b.last  = (i == N - 1);
    return b;
  endfunction

  task automatic push_frame(input logic [41:0] v);
    for (int i = 0; i < N; i++)
      sb.push_back(model(v[7*i +: 7], i));
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      chk("beat_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        beat_t e;
        e = sb.pop_front();
        chk($sformatf("b%0d_index", e.index),
            32'(out_index), 32'(e.index));
        chk($sformatf("b%0d_digit", e.index),
            32'(out_digit), 32'(e.digit));
        chk($sformatf("b%0d_known", e.index),
            32'(out_known), 32'(e.known));
        chk($sformatf("b%0d_blank", e.index),
            32'(out_blank), 32'(e.blank));
        chk($sformatf("b%0d_last", e.index),
            32'(out_last), 32'(e.last));
      end
    end
  end

  task automatic drive(input logic [41:0] v);
    @(posedge clk);
    #2;
    hex = v;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk(tag, 32'(t >= 300), 0);
    repeat (8) @(posedge clk);
  endtask

  task automatic wait_idx(input logic [2:0] ix, input string tag);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!(out_valid && out_index == ix) && t < 100);
    chk(tag, 32'(t >= 100), 0);
  endtask

  initial begin
    logic [41:0] v;
    int          n;
    logic        seen;
    logic        hold;
    logic [3:0]  d0;
    logic [2:0]  i0;

    reset_n   = 1'b0;
    hex       = BLANK;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_digit", 32'(out_digit), 0);
    chk("rst_index", 32'(out_index), 0);
    chk("rst_known", 32'(out_known), 0);
    chk("rst_blank", 32'(out_blank), 1);
    chk("rst_last",  32'(out_last),  0);

    @(posedge clk);
    #2;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("blank_quiet", 32'(seen), 0);

    v = BLANK;
    v[6:0]  = 7'h40;
    v[13:7] = 7'h79;
    drive(v);
    push_frame(v);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 50);
    chk("latency", 32'(n - 1), 32'(SC + 1));
    drain("drain_basic");

    seen = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk);
      #2;
      if (c % 3 == 0)
        hex[6:0] = ((c / 3) % 2 == 1) ? 7'h40 : 7'h08;
      if (out_valid) seen = 1'b1;
    end
    chk("toggle_quiet", 32'(seen), 0);
    v = hex;
    v[6:0] = 7'h08;
    drive(v);
    push_frame(v);
    drain("drain_toggle");

    v = hex;
    v[6:0]   = 7'h40;
    v[27:21] = 7'h7E;
    drive(v);
    push_frame(v);
    wait_idx(3'd2, "bp_reach");
    out_ready = 1'b0;
    d0   = out_digit;
    i0   = out_index;
    hold = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!out_valid || out_digit != d0 || out_index != i0)
        hold = 1'b0;
    end
    chk("bp_hold",  32'(hold), 1);
    chk("bp_index", 32'(out_index), 2);
    out_ready = 1'b1;
    drain("drain_bp");

    v = BLANK;
    v[6:0] = 7'h08;
    drive(v);
    push_frame(v);
    wait_idx(3'd2, "mid_reach");
    v[6:0] = 7'h79;
    hex = v;
    push_frame(v);
    drain("drain_mid");

    v = BLANK;
    v[6:0]  = 7'h40;
    v[13:7] = 7'h79;
    drive(v);
    push_frame(v);
    wait_idx(3'd1, "rst_reach");
    reset_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_index", 32'(out_index), 0);
    chk("abort_blank", 32'(out_blank), 1);
    sb.delete();
    hex = BLANK;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("post_rst_quiet", 32'(seen), 0);

    @(posedge clk);
    #2;
    reset_n = 1'b0;
    v = BLANK;
    v[6:0] = 7'h40;
    hex = v;
    #2;
    reset_n = 1'b1;
    push_frame(v);
    drain("drain_reeval");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
